// File: rtl/systolic_pkg.sv
// Shared types and arithmetic helpers for the output-stationary systolic matmul.
// Build macro SA_SATURATE_EN: clamp results to DATA_WIDTH instead of wrapping.
package systolic_pkg;

`ifdef SA_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  // Cycles for the last injected beat to reach the far-corner PE and settle.
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // Round-half-up at the binary point, then clamp (SATURATE) or leave for truncation.
  // Accumulators up to 63 bits are handled without overflowing the rounding add.
  function automatic logic [63:0] round_narrow(input logic signed [63:0] acc,
                                               input int frac_bits,
                                               input int data_width);
    logic signed [63:0] rnd;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (frac_bits > 0) rnd = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    else               rnd = acc;
    if (SATURATE && rnd > max_v)      rnd = max_v;
    else if (SATURATE && rnd < min_v) rnd = min_v;
    return rnd;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One processing element: signed MAC into a local accumulator, with a and b
// forwarded right/down through one register each.
module sa_pe #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] a_pass,
  output logic signed [DATA_WIDTH-1:0] b_pass,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;

  assign prod     = a * b;
  assign prod_ext = ACC_WIDTH'(prod);

  // NOTE: non-blocking assignments so every PE samples its neighbour's value
  // from before the edge; blocking here would ripple data across the array.
  // NOTE: the accumulator is state, not a memory, so it is reset like any register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_pass <= '0;
      b_pass <= '0;
      acc    <= '0;
    end else begin
      a_pass <= a;
      b_pass <= b;
      acc    <= clear ? prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_matmul_os.sv
// Output-stationary ROWS x COLS systolic array computing C = A*B, one k-beat per cycle.
// Build macro SA_SATURATE_EN selects saturating result narrowing (default: wrap).
module systolic_matmul_os
  import systolic_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_BITS  = 8,
  localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [ROWS*DATA_WIDTH-1:0] in_a,
  input  logic [COLS*DATA_WIDTH-1:0] in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLS*DATA_WIDTH-1:0] out_row,
  output logic [IDX_W-1:0]           out_row_idx,
  output logic                       out_last,
  output logic                       busy
);

  localparam int FLUSH_LEN = flush_len(ROWS, COLS);
  localparam int CNT_W     = $clog2(FLUSH_LEN + 1);

  state_t                        state;
  logic [CNT_W-1:0]              flush_cnt;
  logic                          accept;
  logic                          clear;
  logic [IDX_W-1:0]              next_idx;
  logic [COLS*DATA_WIDTH-1:0]    next_row;
  logic signed [DATA_WIDTH-1:0]  a_h      [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]  b_v      [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]  a_unused [ROWS];
  logic signed [DATA_WIDTH-1:0]  b_unused [COLS];
  logic signed [ACC_WIDTH-1:0]   pe_acc   [ROWS][COLS];

  assign in_ready = !rst && (state == IDLE || state == LOAD);
  assign accept   = in_valid && in_ready;
  assign clear    = accept && (state == IDLE);
  assign busy     = (state != IDLE);

  // Edge skew: row r / column c see their operand r / c cycles late; idle cycles inject 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic signed [DATA_WIDTH-1:0] gated;
    assign gated = accept ? in_a[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_direct
      assign a_h[r][0] = gated;
    end else begin : g_delay
      logic signed [DATA_WIDTH-1:0] dly [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) dly[i] <= '0;
        end else begin
          dly[0] <= gated;
          for (int i = 1; i < r; i++) dly[i] <= dly[i-1];
        end
      end
      assign a_h[r][0] = dly[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic signed [DATA_WIDTH-1:0] gated;
    assign gated = accept ? in_b[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (c == 0) begin : g_direct
      assign b_v[0][c] = gated;
    end else begin : g_delay
      logic signed [DATA_WIDTH-1:0] dly [c];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c; i++) dly[i] <= '0;
        end else begin
          dly[0] <= gated;
          for (int i = 1; i < c; i++) dly[i] <= dly[i-1];
        end
      end
      assign b_v[0][c] = dly[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DATA_WIDTH-1:0] a_pass;
      logic signed [DATA_WIDTH-1:0] b_pass;
      sa_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .a      (a_h[r][c]),
        .b      (b_v[r][c]),
        .a_pass (a_pass),
        .b_pass (b_pass),
        .acc    (pe_acc[r][c])
      );
      if (c < COLS - 1) begin : g_a_next
        assign a_h[r][c+1] = a_pass;
      end else begin : g_a_end
        assign a_unused[r] = a_pass;
      end
      if (r < ROWS - 1) begin : g_b_next
        assign b_v[r+1][c] = b_pass;
      end else begin : g_b_end
        assign b_unused[c] = b_pass;
      end
    end
  end

  assign next_idx = out_valid ? out_row_idx + 1'b1 : '0;

  // NOTE: default assignment first so no path leaves next_row unassigned (no latch).
  always_comb begin
    next_row = '0;
    for (int c = 0; c < COLS; c++) begin
      next_row[c*DATA_WIDTH +: DATA_WIDTH] =
        DATA_WIDTH'(round_narrow(64'(pe_acc[next_idx][c]), FRAC_BITS, DATA_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_row     <= '0;
      out_row_idx <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state     <= in_last ? FLUSH : LOAD;
          flush_cnt <= '0;
        end
        LOAD: if (accept && in_last) begin
          state     <= FLUSH;
          flush_cnt <= '0;
        end
        FLUSH: begin
          if (flush_cnt == CNT_W'(FLUSH_LEN - 1)) state <= DRAIN;
          else                                    flush_cnt <= flush_cnt + 1'b1;
        end
        DRAIN: begin
          // First DRAIN cycle registers row 0; each later handshake advances one row.
          if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
          end else if (!out_valid || out_ready) begin
            out_valid   <= 1'b1;
            out_row     <= next_row;
            out_row_idx <= next_idx;
            out_last    <= (next_idx == IDX_W'(ROWS - 1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_matmul_os.sv
// Directed, table-driven bench for a 2x2 Q8.8 systolic_matmul_os, plus
// hand-written sequences for output back-pressure and mid-job reset.
module tb_systolic_matmul_os;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int DW   = 16;
  localparam int MAXK = 4;
  localparam int NVEC = 5;

`ifdef SA_SATURATE_EN
  localparam logic [DW-1:0] OVF = 16'h7FFF;
`else
  localparam logic [DW-1:0] OVF = 16'h0400;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_ready = 1'b1;
  logic [ROWS*DW-1:0]   in_a = '0;
  logic [COLS*DW-1:0]   in_b = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic [COLS*DW-1:0]   out_row;
  logic [0:0]           out_row_idx;
  logic                 out_last;
  logic                 busy;

  systolic_matmul_os #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(40), .FRAC_BITS(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // a[k] = column k of A {A[1][k],A[0][k]}; b[k] = row k of B {B[k][1],B[k][0]};
  // c[r] = result row r {C[r][1],C[r][0]}.
  typedef struct {
    string                          name;
    int                             nbeats;
    logic [MAXK-1:0][ROWS*DW-1:0]   a;
    logic [MAXK-1:0][COLS*DW-1:0]   b;
    logic [ROWS-1:0][COLS*DW-1:0]   c;
  } vec_t;

  vec_t vecs [NVEC];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_job(input vec_t v);
    for (int k = 0; k < v.nbeats; k++) begin
      in_valid = 1'b1;
      in_a     = v.a[k];
      in_b     = v.b[k];
      in_last  = (k == v.nbeats - 1);
      check($sformatf("%s beat%0d in_ready", v.name, k), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input vec_t v, input int stall_row, input int stall_cycles);
    for (int r = 0; r < ROWS; r++) begin
      int w = 0;
      while (!out_valid && w < 10) begin
        @(posedge clk); #1;
        w++;
      end
      check($sformatf("%s row%0d valid", v.name, r), 64'(out_valid), 64'd1);
      check($sformatf("%s row%0d idx", v.name, r), 64'(out_row_idx), 64'(r));
      check($sformatf("%s row%0d data", v.name, r), 64'(out_row), 64'(v.c[r]));
      check($sformatf("%s row%0d last", v.name, r), 64'(out_last), 64'(r == ROWS - 1));
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          @(posedge clk); #1;
          check($sformatf("%s stall%0d valid", v.name, s), 64'(out_valid), 64'd1);
          check($sformatf("%s stall%0d data", v.name, s), 64'(out_row), 64'(v.c[r]));
          check($sformatf("%s stall%0d idx", v.name, s), 64'(out_row_idx), 64'(r));
          check($sformatf("%s stall%0d last", v.name, s), 64'(out_last), 64'(r == ROWS - 1));
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    check($sformatf("%s no extra row", v.name), 64'(out_valid), 64'd0);
    check($sformatf("%s idle after drain", v.name), 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;

    for (int i = 0; i < NVEC; i++) begin
      vecs[i].a = '0;
      vecs[i].b = '0;
      vecs[i].c = '0;
    end
    // A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> [[19,22],[43,50]]
    vecs[0].name = "basic2x2"; vecs[0].nbeats = 2;
    vecs[0].a[0] = {16'h0300, 16'h0100}; vecs[0].a[1] = {16'h0400, 16'h0200};
    vecs[0].b[0] = {16'h0600, 16'h0500}; vecs[0].b[1] = {16'h0800, 16'h0700};
    vecs[0].c[0] = {16'h1600, 16'h1300}; vecs[0].c[1] = {16'h3200, 16'h2B00};
    // K=1 outer product [1,2]x[3,4]
    vecs[1].name = "single_beat"; vecs[1].nbeats = 1;
    vecs[1].a[0] = {16'h0200, 16'h0100}; vecs[1].b[0] = {16'h0400, 16'h0300};
    vecs[1].c[0] = {16'h0400, 16'h0300}; vecs[1].c[1] = {16'h0800, 16'h0600};
    // A=[[2,-0.5],[-1,1.5]], B=[[3,0.5],[4,-2]] -> [[4,2],[3,-3.5]]
    vecs[2].name = "signed_mix"; vecs[2].nbeats = 2;
    vecs[2].a[0] = {16'hFF00, 16'h0200}; vecs[2].a[1] = {16'h0180, 16'hFF80};
    vecs[2].b[0] = {16'h0080, 16'h0300}; vecs[2].b[1] = {16'hFE00, 16'h0400};
    vecs[2].c[0] = {16'h0200, 16'h0400}; vecs[2].c[1] = {16'hFC80, 16'h0300};
    // Raw products 0x80 -> 1, 0x7F -> 0, -0x80 -> 0, -0x7F -> 0
    vecs[3].name = "rounding"; vecs[3].nbeats = 1;
    vecs[3].a[0] = {16'hFFFF, 16'h0001}; vecs[3].b[0] = {16'h007F, 16'h0080};
    vecs[3].c[0] = {16'h0000, 16'h0001}; vecs[3].c[1] = '0;
    // Four beats of 0x7F00*0x7F00: rounded 0xFC0400
    vecs[4].name = "overflow"; vecs[4].nbeats = 4;
    for (int k = 0; k < 4; k++) begin
      vecs[4].a[k] = {16'h7F00, 16'h7F00};
      vecs[4].b[k] = {16'h7F00, 16'h7F00};
    end
    vecs[4].c[0] = {OVF, OVF}; vecs[4].c[1] = {OVF, OVF};

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_row", 64'(out_row), 64'd0);
    check("reset out_row_idx", 64'(out_row_idx), 64'd0);
    check("reset out_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", 64'(in_ready), 64'd1);

    // Jobs run back to back; job 0 also holds row 1 under back-pressure for 3 cycles.
    for (int i = 0; i < NVEC; i++) begin
      send_job(vecs[i]);
      wait_valid(lat);
      check($sformatf("%s latency", vecs[i].name), 64'(lat), 64'(ROWS + COLS));
      drain(vecs[i], (i == 0) ? 1 : -1, 3);
    end

    // Reset during FLUSH: array returns to IDLE, no rows appear, next job is clean.
    send_job(vecs[0]);
    @(posedge clk); #1;
    check("flush busy", 64'(busy), 64'd1);
    check("flush in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("midrst in_ready release", 64'(in_ready), 64'd1);
    seen = 0;
    for (int s = 0; s < 8; s++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst no out_valid", 64'(seen), 64'd0);
    send_job(vecs[2]);
    wait_valid(lat);
    check("post-reset latency", 64'(lat), 64'(ROWS + COLS));
    drain(vecs[2], -1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
